// File: rtl/fl32_accumulator.sv
// fl32_accumulator
//   Streams IEEE-754 single elements into a running sum using an external
//   combinational fp32 adder. The first element of a stream is loaded
//   directly; each later element is added through the adder. Accepting the
//   element flagged in_last produces a result that is held until the consumer
//   takes it.
//
// Optional feature (macro FL32_ACC_SPECIAL_STICKY_EN):
//   once the accumulator holds inf/NaN (exponent 8'hFF) it freezes for the
//   rest of the stream and out_special reports it. Without the macro the
//   accumulator always loads add_out and out_special is tied low.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; valid never waits for ready, and ready/valid outputs here are
//   pure decodes of registered state.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input element handshake
//   in_data, in_last     fp32 element and end-of-stream flag
//   add_in_0, add_in_1   operands to the external adder (acc, in_data)
//   add_out              adder result, same cycle
//   out_valid/out_ready  result handshake
//   out_sum, out_count   accumulated sum and element count (saturating)
//   out_special          accumulated value is inf/NaN
//   busy                 stream in progress or result pending
//   dbg_state            current FSM state (0 IDLE, 1 ACCUM, 2 DONE)

module fl32_accumulator #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      add_in_0,
    output logic [31:0]      add_in_1,
    input  logic [31:0]      add_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_special,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             acc_is_special;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      acc_next_sum;

    assign acc_is_special = (acc_q[30:23] == 8'hFF);

    // Count sticks at its maximum rather than wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

`ifdef FL32_ACC_SPECIAL_STICKY_EN
    // An inf/NaN accumulator is frozen so the first special value survives.
    assign acc_next_sum = acc_is_special ? acc_q : add_out;
    assign out_special  = acc_is_special;
`else
    assign acc_next_sum = add_out;
    assign out_special  = 1'b0;
`endif

    // Status outputs decode registered state only.
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    assign accept    = in_valid && in_ready;

    assign add_in_0  = acc_q;
    assign add_in_1  = in_data;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = in_data;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d   = acc_next_sum;
                    cnt_d   = cnt_inc;
                    state_d = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    acc_d   = 32'h0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = 32'h0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/fl32_accumulator.md
FL32_ACCUMULATOR -- requirements
Module: fl32_accumulator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 9, giving the element-count width (saturates at 2^CNT_W-1).
REQ-002 The block SHALL have the following ports, with clock and reset first:
  clk  in  1  sole clock; all state updates on rising edge.
  rst_n  in  1  reset; asynchronous, active-low.
  in_valid  in  1  in_data/in_last valid.
  in_ready  out  1  block accepts an element this cycle.
  in_data  in  32  IEEE-754 single element.
  in_last  in  1  element is the last of the current stream.
  add_in_0  out  32  operand A to the combinational fp32 adder.
  add_in_1  out  32  operand B to the combinational fp32 adder.
  add_out  in  32  adder result for add_in_0 + add_in_1, same cycle.
  out_valid  out  1  out_sum/out_count/out_special valid.
  out_ready  in  1  consumer takes the result.
  out_sum  out  32  accumulated fp32 sum.
  out_count  out  CNT_W  number of elements accepted in the stream.
  out_special  out  1  accumulated value is inf/NaN (exponent 8'hFF).
  busy  out  1  high in ACCUM or DONE.

Function
REQ-003 The block SHALL define an element as accepted in any cycle where in_valid and in_ready are both high.
REQ-004 The block SHALL implement states IDLE, ACCUM and DONE.
REQ-005 In IDLE, in_ready=1; on accept: acc<=in_data (no add), count<=1, then ->DONE if in_last, else ->ACCUM.
REQ-006 In ACCUM, in_ready=1; on accept: acc<=add_out, count<=count+1 (saturating), then ->DONE if in_last, else stay.
REQ-007 In ACCUM without accept (in_valid low), acc, count and state SHALL hold.
REQ-008 add_in_0 SHALL equal acc and add_in_1 SHALL equal in_data combinationally in every state.
REQ-009 In DONE: in_ready=0, out_valid=1; out_sum=acc, out_count=count.
REQ-010 In DONE, out_sum, out_count and out_special SHALL hold stable while out_ready is low.
REQ-011 In DONE with out_ready=1: ->IDLE, with acc<=0 and count<=0 next cycle.
REQ-012 Latency SHALL be 1 cycle: out_valid rises on the edge that accepts in_last.
REQ-013 The block SHALL sustain one element per cycle; out_valid and in_ready SHALL never both be high.
REQ-014 In DONE, in_valid SHALL be ignored; the element is not consumed.
REQ-015 When count equals 2^CNT_W-1, further accepts SHALL still update acc while count holds.
REQ-016 out_valid, in_ready and busy SHALL be registered-state decodes with no combinational path from out_ready.

Reset
REQ-017 While rst_n=0: state=IDLE, acc=32'h0, count=0, out_valid=0, out_special=0, busy=0; in_ready=1 after release.
REQ-018 Reset asserted mid-stream SHALL discard the partial sum; the next accepted element starts a new stream.

Configuration
REQ-019 With macro FL32_ACC_SPECIAL_STICKY_EN defined: once acc[30:23]==8'hFF, acc SHALL freeze for the rest of the stream while count still increments, and out_special=(acc[30:23]==8'hFF).
REQ-020 With FL32_ACC_SPECIAL_STICKY_EN undefined: acc SHALL always load add_out per REQ-006, and out_special SHALL be tied 0.

Verification
REQ-021 Single-element stream, 0x3F800000 with in_last -> next cycle out_valid=1, out_sum=0x3F800000, out_count=1.
REQ-022 Stream 0x3F800000, 0x40000000, 0x40400000(last) on back-to-back cycles -> out_sum=0x40C00000, out_count=3, out_valid one cycle after the third accept.
REQ-023 Stream 1.0, [in_valid low 3 cycles], 1.0(last) -> out_sum=0x40000000, out_count=2; acc unchanged during the gap.
REQ-024 In DONE hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no element consumed; out_ready=1 -> IDLE next cycle, then a new stream accepted.
REQ-025 Sticky macro defined: stream 0x3F800000, 0x7FC00000, 0x40000000(last) -> out_sum=0x7FC00000, out_special=1, out_count=3; undefined -> out_special=0.
REQ-026 Assert rst_n=0 after 2 accepted elements -> out_valid=0, busy=0; stream 0x40400000(last) -> out_sum=0x40400000, out_count=1.
